// File: rtl/vote_logger.sv
// vote_logger: per-candidate vote tally with single-voter lockout and result
// readout. Each accepted one-hot valid_vote pulse bumps a saturating tally and
// starts a LOCKOUT-cycle hold during which further pulses are ignored. In result
// mode the tally of candidate sel is presented on count_out.
//
// Optional feature: define VOTE_TOTAL_EN to add the total_votes output, a
// saturating count of every accepted vote.
module vote_logger #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int LOCKOUT  = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                mode,
    input  logic [NUM_CAND-1:0]                 valid_vote,
    input  logic [$clog2(NUM_CAND)-1:0]         sel,
    output logic                                vote_accepted,
    output logic                                multi_err,
    output logic                                busy,
    output logic [CNT_W-1:0]                    count_out
`ifdef VOTE_TOTAL_EN
    ,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total_votes
`endif
);

    localparam int SEL_W = $clog2(NUM_CAND);
    localparam int CTR_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

    localparam logic [SEL_W:0]     NUM_CAND_W = (SEL_W + 1)'(NUM_CAND);
    localparam logic [CTR_W-1:0]   CTR_LOAD   = CTR_W'(LOCKOUT - 1);
    localparam logic [CNT_W-1:0]   TALLY_MAX  = '1;

    typedef enum logic [1:0] {
        S_VOTE   = 2'd0,
        S_HOLD   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CTR_W-1:0]     ctr;
    logic [CTR_W-1:0]     ctr_next;
    logic                 accept_next;
    logic                 err_next;
    logic                 busy_next;
    logic [CNT_W-1:0]     count_next;

    logic [CNT_W-1:0]     tally [NUM_CAND];

    logic [NUM_CAND-1:0]  vote_low_cleared;
    logic                 one_hot;
    logic                 multi_hot;
    logic [SEL_W-1:0]     vote_idx;
    logic                 sel_ok;

    // Classify the incoming pulses: exactly one bit set, or two or more.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        vote_low_cleared = valid_vote & (valid_vote - NUM_CAND'(1));
        one_hot          = (valid_vote != '0) && (vote_low_cleared == '0);
        multi_hot        = (valid_vote != '0) && (vote_low_cleared != '0);
    end

    // Encode the position of the single set bit (only used when one_hot).
    always_comb begin
        vote_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (valid_vote[i]) begin
                vote_idx = SEL_W'(i);
            end
        end
    end

    // Candidate indices beyond the configured range read back as zero.
    assign sel_ok = ({1'b0, sel} < NUM_CAND_W);

    // Next-state, lockout counter and next output values.
    always_comb begin
        state_next  = state;
        ctr_next    = ctr;
        accept_next = 1'b0;
        err_next    = 1'b0;
        busy_next   = 1'b0;
        count_next  = '0;

        unique case (state)
            S_VOTE: begin
                if (mode) begin
                    // Entering readout takes priority; pulses this cycle are dropped.
                    state_next = S_RESULT;
                end else if (one_hot) begin
                    accept_next = 1'b1;
                    busy_next   = 1'b1;
                    ctr_next    = CTR_LOAD;
                    state_next  = S_HOLD;
                end else if (multi_hot) begin
                    err_next = 1'b1;
                end
            end

            S_HOLD: begin
                // busy stays high for LOCKOUT cycles: the load cycle plus
                // LOCKOUT-1 decrements; the exit happens on the ctr==0 cycle.
                if (ctr == '0) begin
                    state_next = mode ? S_RESULT : S_VOTE;
                end else begin
                    ctr_next  = ctr - 1'b1;
                    busy_next = 1'b1;
                end
            end

            S_RESULT: begin
                if (!mode) begin
                    state_next = S_VOTE;
                end
            end

            default: begin
                state_next = S_VOTE;
            end
        endcase

        // count_out tracks the state it is registered alongside, so it is
        // non-zero only while the registered state is S_RESULT. Tallies never
        // change on a transition into S_RESULT, so the current value is exact.
        if ((state_next == S_RESULT) && sel_ok) begin
            count_next = tally[sel];
        end
    end

    // State register, lockout counter and registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state         <= S_VOTE;
            ctr           <= '0;
            vote_accepted <= 1'b0;
            multi_err     <= 1'b0;
            busy          <= 1'b0;
            count_out     <= '0;
        end else begin
            state         <= state_next;
            ctr           <= ctr_next;
            vote_accepted <= accept_next;
            multi_err     <= err_next;
            busy          <= busy_next;
            count_out     <= count_next;
        end
    end

    // Per-candidate saturating tallies.
    always_ff @(posedge clock) begin
        // NOTE: the tally array is cleared by reset because a fresh election
        // must start from zero; storage that only holds data would be left
        // unreset.
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
        end else if (accept_next && (tally[vote_idx] != TALLY_MAX)) begin
            tally[vote_idx] <= tally[vote_idx] + CNT_W'(1);
        end
    end

`ifdef VOTE_TOTAL_EN
    localparam int                 TOT_W   = CNT_W + SEL_W;
    localparam logic [TOT_W-1:0]   TOT_MAX = '1;

    // Grand total of accepted votes, including those taken at per-candidate
    // saturation; saturates at its own maximum.
    always_ff @(posedge clock) begin
        if (!reset) begin
            total_votes <= '0;
        end else if (accept_next && (total_votes != TOT_MAX)) begin
            total_votes <= total_votes + TOT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vote_logger.sv
// Directed testbench for vote_logger (NUM_CAND=4, CNT_W=8, LOCKOUT=16).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. after the edge that registered them.
module tb_vote_logger;

    logic        clock;
    logic        reset;
    logic        mode;
    logic [3:0]  valid_vote;
    logic [1:0]  sel;
    logic        vote_accepted;
    logic        multi_err;
    logic        busy;
    logic [7:0]  count_out;
`ifdef VOTE_TOTAL_EN
    logic [9:0]  total_votes;
`endif

    int checks = 0;
    int errors = 0;

    vote_logger #(
        .NUM_CAND (4),
        .CNT_W    (8),
        .LOCKOUT  (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .valid_vote    (valid_vote),
        .sel           (sel),
        .vote_accepted (vote_accepted),
        .multi_err     (multi_err),
        .busy          (busy),
        .count_out     (count_out)
`ifdef VOTE_TOTAL_EN
        ,
        .total_votes   (total_votes)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read the tally of candidate s through result mode; returns to S_VOTE.
    task automatic read_tally(input logic [1:0] s, output logic [7:0] v);
        mode = 1'b1;
        sel  = s;
        tick();
        v    = count_out;
        mode = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b0;
        mode = 1'b0;
        valid_vote = 4'b0000;
        sel = 2'd0;
        repeat (2) tick();
        checks++;
        if (vote_accepted !== 1'b0 || multi_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got acc=%b err=%b busy=%b want 0/0/0",
                     vote_accepted, multi_err, busy);
        end
        checks++;
        if (count_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_count_out: got %0d want 0", count_out);
        end
`ifdef VOTE_TOTAL_EN
        checks++;
        if (total_votes !== 10'd0) begin
            errors++;
            $display("FAIL reset_total: got %0d want 0", total_votes);
        end
`endif
        reset = 1'b1;
        mode  = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            v = count_out;
            checks++;
            if (v !== 8'd0) begin
                errors++;
                $display("FAIL reset_tally_%0d: got %0d want 0", s, v);
            end
        end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_vote();
        int busy_cycles;
        int acc;
        logic [7:0] v;
        valid_vote = 4'b0010;
        tick();
        checks++;
        if (vote_accepted !== 1'b1 || busy !== 1'b1 || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL vote_pulse: got acc=%b busy=%b err=%b want 1/1/0",
                     vote_accepted, busy, multi_err);
        end
        valid_vote = 4'b0000;
        busy_cycles = 1;
        acc = 0;
        repeat (20) begin
            tick();
            busy_cycles += int'(busy);
            acc += int'(vote_accepted);
        end
        checks++;
        if (busy_cycles != 16) begin
            errors++;
            $display("FAIL vote_busy_len: got %0d cycles want 16", busy_cycles);
        end
        checks++;
        if (acc != 0) begin
            errors++;
            $display("FAIL vote_single_pulse: got %0d extra pulses want 0", acc);
        end
        read_tally(2'd1, v);
        checks++;
        if (v !== 8'd1) begin
            errors++;
            $display("FAIL vote_tally1: got %0d want 1", v);
        end
        read_tally(2'd0, v);
        checks++;
        if (v !== 8'd0) begin
            errors++;
            $display("FAIL vote_tally0: got %0d want 0", v);
        end
    endtask

    task automatic test_multi();
        logic [7:0] v;
        valid_vote = 4'b0110;
        tick();
        checks++;
        if (multi_err !== 1'b1 || vote_accepted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_pulse: got err=%b acc=%b busy=%b want 1/0/0",
                     multi_err, vote_accepted, busy);
        end
        valid_vote = 4'b0000;
        tick();
        checks++;
        if (multi_err !== 1'b0) begin
            errors++;
            $display("FAIL multi_one_cycle: got %b want 0", multi_err);
        end
        read_tally(2'd1, v);
        checks++;
        if (v !== 8'd1) begin
            errors++;
            $display("FAIL multi_tally1: got %0d want 1", v);
        end
        read_tally(2'd2, v);
        checks++;
        if (v !== 8'd0) begin
            errors++;
            $display("FAIL multi_tally2: got %0d want 0", v);
        end
    endtask

    task automatic test_lockout();
        logic [7:0] v;
        // Lockout started by candidate 2 (edge 0).
        valid_vote = 4'b0100;
        tick();
        valid_vote = 4'b0000;
        repeat (4) tick();
        // Lockout cycle 5: single pulse on bit 0.
        valid_vote = 4'b0001;
        tick();
        checks++;
        if (vote_accepted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_ignore: got acc=%b busy=%b want 0/1", vote_accepted, busy);
        end
        // Multi-bit pulse during lockout must not raise multi_err.
        valid_vote = 4'b0011;
        tick();
        checks++;
        if (multi_err !== 1'b0) begin
            errors++;
            $display("FAIL lock_no_err: got %b want 0", multi_err);
        end
        valid_vote = 4'b0000;
        repeat (9) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_last_busy: got %b want 1", busy);
        end
        // Pulse in the final busy cycle is still ignored.
        valid_vote = 4'b0001;
        tick();
        checks++;
        if (busy !== 1'b0 || vote_accepted !== 1'b0) begin
            errors++;
            $display("FAIL lock_edge_ignore: got busy=%b acc=%b want 0/0", busy, vote_accepted);
        end
        // Same pulse one cycle after busy falls is counted.
        tick();
        checks++;
        if (vote_accepted !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_accept: got acc=%b busy=%b want 1/1", vote_accepted, busy);
        end
        valid_vote = 4'b0000;
        repeat (16) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got %b want 0", busy);
        end
        read_tally(2'd0, v);
        checks++;
        if (v !== 8'd1) begin
            errors++;
            $display("FAIL lock_tally0: got %0d want 1", v);
        end
        read_tally(2'd2, v);
        checks++;
        if (v !== 8'd1) begin
            errors++;
            $display("FAIL lock_tally2: got %0d want 1", v);
        end
    endtask

    // Tallies here: [1,1,1,0].
    task automatic test_back_to_back();
        // mode=1 in S_VOTE drops a simultaneous vote.
        mode = 1'b1;
        sel = 2'd0;
        valid_vote = 4'b0001;
        tick();
        checks++;
        if (vote_accepted !== 1'b0 || busy !== 1'b0 || count_out !== 8'd1) begin
            errors++;
            $display("FAIL b2b_mode_priority: got acc=%b busy=%b cnt=%0d want 0/0/1",
                     vote_accepted, busy, count_out);
        end
        valid_vote = 4'b0000;
        sel = 2'd3;
        tick();
        checks++;
        if (count_out !== 8'd0) begin
            errors++;
            $display("FAIL b2b_sel_change: got %0d want 0", count_out);
        end
        valid_vote = 4'b1000;
        sel = 2'd2;
        tick();
        checks++;
        if (vote_accepted !== 1'b0 || count_out !== 8'd1) begin
            errors++;
            $display("FAIL b2b_result_ignore: got acc=%b cnt=%0d want 0/1", vote_accepted, count_out);
        end
        valid_vote = 4'b0000;
        mode = 1'b0;
        tick();
        checks++;
        if (count_out !== 8'd0) begin
            errors++;
            $display("FAIL b2b_exit_result: got %0d want 0", count_out);
        end
        // Vote, then request readout during hold: exit goes straight to S_RESULT.
        valid_vote = 4'b0001;
        tick();
        valid_vote = 4'b0000;
        mode = 1'b1;
        sel = 2'd0;
        repeat (15) tick();
        checks++;
        if (busy !== 1'b1 || count_out !== 8'd0) begin
            errors++;
            $display("FAIL b2b_hold_readout: got busy=%b cnt=%0d want 1/0", busy, count_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || count_out !== 8'd2) begin
            errors++;
            $display("FAIL b2b_hold_to_result: got busy=%b cnt=%0d want 0/2", busy, count_out);
        end
        mode = 1'b0;
        tick();
`ifdef VOTE_TOTAL_EN
        checks++;
        if (total_votes !== 10'd4) begin
            errors++;
            $display("FAIL b2b_total: got %0d want 4", total_votes);
        end
`endif
    endtask

    task automatic test_saturation();
        int acc;
        logic last_busy;
        logic [7:0] v;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        acc = 0;
        last_busy = 1'b0;
        for (int n = 0; n < 260; n++) begin
            valid_vote = 4'b1000;
            tick();
            acc += int'(vote_accepted);
            last_busy = busy;
            valid_vote = 4'b0000;
            repeat (16) begin
                tick();
                acc += int'(vote_accepted);
            end
        end
        checks++;
        if (acc != 260) begin
            errors++;
            $display("FAIL sat_pulses: got %0d want 260", acc);
        end
        checks++;
        if (last_busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_enters_hold: got busy=%b want 1", last_busy);
        end
        read_tally(2'd3, v);
        checks++;
        if (v !== 8'd255) begin
            errors++;
            $display("FAIL sat_tally3: got %0d want 255", v);
        end
        read_tally(2'd0, v);
        checks++;
        if (v !== 8'd0) begin
            errors++;
            $display("FAIL sat_tally0_cleared: got %0d want 0", v);
        end
`ifdef VOTE_TOTAL_EN
        checks++;
        if (total_votes !== 10'd260) begin
            errors++;
            $display("FAIL sat_total: got %0d want 260", total_votes);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        // Reset in the middle of S_HOLD.
        valid_vote = 4'b0100;
        tick();
        valid_vote = 4'b0000;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || vote_accepted !== 1'b0 || count_out !== 8'd0) begin
            errors++;
            $display("FAIL rst_hold: got busy=%b acc=%b cnt=%0d want 0/0/0",
                     busy, vote_accepted, count_out);
        end
        reset = 1'b1;
        valid_vote = 4'b0100;
        tick();
        checks++;
        if (vote_accepted !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_vote_state: got acc=%b want 1", vote_accepted);
        end
        valid_vote = 4'b0000;
        repeat (16) tick();
        read_tally(2'd3, v);
        checks++;
        if (v !== 8'd0) begin
            errors++;
            $display("FAIL rst_tally3_cleared: got %0d want 0", v);
        end
        // Reset while in S_RESULT showing a non-zero tally.
        mode = 1'b1;
        sel = 2'd2;
        tick();
        checks++;
        if (count_out !== 8'd1) begin
            errors++;
            $display("FAIL rst_result_pre: got %0d want 1", count_out);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (count_out !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_result: got cnt=%0d busy=%b want 0/0", count_out, busy);
        end
`ifdef VOTE_TOTAL_EN
        checks++;
        if (total_votes !== 10'd0) begin
            errors++;
            $display("FAIL rst_total: got %0d want 0", total_votes);
        end
`endif
        reset = 1'b1;
        mode = 1'b0;
        valid_vote = 4'b0001;
        tick();
        checks++;
        if (vote_accepted !== 1'b1) begin
            errors++;
            $display("FAIL rst_result_vote_state: got acc=%b want 1", vote_accepted);
        end
        valid_vote = 4'b0000;
        repeat (16) tick();
        read_tally(2'd2, v);
        checks++;
        if (v !== 8'd0) begin
            errors++;
            $display("FAIL rst_tally2_cleared: got %0d want 0", v);
        end
        read_tally(2'd0, v);
        checks++;
        if (v !== 8'd1) begin
            errors++;
            $display("FAIL rst_tally0_new: got %0d want 1", v);
        end
    endtask

    initial begin
        test_reset();
        test_vote();
        test_multi();
        test_lockout();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
